// File: rtl/poly_operand_driver.sv
// poly_operand_driver: replays A, B, C, X to a button-style polynomial evaluator and captures its result.
// Latency: 1+GO_HIGH+GO_LOW cycles per operand, then up to TIMEOUT cycles waiting for ResultValid.
// Backpressure: none; Start is honoured only in IDLE, and every output is driven from a register.
module poly_operand_driver #(
  parameter int WIDTH   = 8,
  parameter int GO_HIGH = 2,
  parameter int GO_LOW  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [WIDTH-1:0] OpC,
  input  logic [WIDTH-1:0] OpX,
  input  logic             ResultValid,
  input  logic [WIDTH-1:0] DataResult,
  output logic             Go,
  output logic [WIDTH-1:0] DataOut,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [WIDTH-1:0] Result
);

  // One shared counter covers the Go-high, Go-low and result-wait phases.
  localparam int CNT_MAX_HL = (GO_HIGH > GO_LOW) ? GO_HIGH : GO_LOW;
  localparam int CNT_MAX    = (CNT_MAX_HL > TIMEOUT) ? CNT_MAX_HL : TIMEOUT;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HI_LAST = CW'(GO_HIGH - 1);
  localparam logic [CW-1:0] LO_LAST = CW'(GO_LOW - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_GO_HI = 3'd2,
    ST_GO_LO = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ops_q [4];
  logic [WIDTH-1:0] ops_d [4];

  logic             capture, expire;

  logic             go_q, go_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH-1:0] result_q, result_d;

  // State register together with operand index, phase counter and operand latches.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) ops_q[i] <= ops_d[i];
    end
  end

  // Next-state logic; a result arriving on the final wait cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          ops_d[0] = OpA;
          ops_d[1] = OpB;
          ops_d[2] = OpC;
          ops_d[3] = OpX;
          idx_d    = 2'd0;
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_GO_HI;
      end
      ST_GO_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d   = '0;
          state_d = ST_GO_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GO_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = ST_WAIT;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (ResultValid) begin
          capture = 1'b1;
          cnt_d   = '0;
          idx_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          expire  = 1'b1;
          cnt_d   = '0;
          idx_d   = 2'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    go_d     = (state_d == ST_GO_HI);
    busy_d   = (state_d != ST_IDLE);
    done_d   = capture;
    tmo_d    = expire;
    result_d = capture ? DataResult : result_q;
    dout_d   = '0;
    if (state_d == ST_SETUP || state_d == ST_GO_HI || state_d == ST_GO_LO) begin
      dout_d = ops_d[idx_d];
    end
  end

  // Output registers, so no output depends combinationally on an input.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      go_q     <= 1'b0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      result_q <= '0;
    end else begin
      go_q     <= go_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
    end
  end

  assign Go      = go_q;
  assign DataOut = dout_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Timeout = tmo_q;
  assign Result  = result_q;

endmodule
